// File: rtl/frame_validator.sv
// frame_validator: checks completed thermostat frames from the Manchester decoder and publishes
// a payload once it has been received REPEAT times in a row without a bad frame in between.
//
// Ports:
//   clk, rst_n                  system clock, asynchronous active-low reset
//   frame_full                  decoder full flag; its rising edge marks a completed frame
//   preamble .. state           decoded frame fields, held stable while frame_full is high
//   out_valid/out_ready         one-entry valid/ready output register
//   out_thermostat_id .. out_state  published payload, changes only on publish
//   good_count, bad_count       saturating frame statistics
//   last_error                  error code of the most recent bad frame
//   overrun                     sticky, an unaccepted payload was overwritten
//   stale                       no publish within the last TIMEOUT cycles
module frame_validator #(
  parameter logic [31:0] PREAMBLE = 32'hAAAA_AAAA,
  parameter logic [31:0] CONSTANT = 32'h0000_0000,
  parameter logic [15:0] TEMP_MIN = 16'd320,
  parameter logic [15:0] TEMP_MAX = 16'd990,
  parameter int unsigned REPEAT   = 2,
  parameter logic [23:0] TIMEOUT  = 24'd12_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_full,
  input  logic [31:0] preamble,
  input  logic [15:0] type_1,
  input  logic [15:0] type_2,
  input  logic [31:0] constant,
  input  logic [31:0] thermostat_id,
  input  logic [15:0] room_temp,
  input  logic [15:0] set_temp,
  input  logic [7:0]  state,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_thermostat_id,
  output logic [15:0] out_room_temp,
  output logic [15:0] out_set_temp,
  output logic [7:0]  out_state,
  output logic [7:0]  good_count,
  output logic [7:0]  bad_count,
  output logic [2:0]  last_error,
  output logic        overrun,
  output logic        stale
);

  localparam logic [3:0] RepeatCnt = 4'(REPEAT);

  typedef enum logic [1:0] {StWait, StCheck, StCommit} st_e;

  st_e         st_q, st_d;
  logic        full_q, full_d;
  // Cleared by reset so a frame_full already high at reset release creates no event.
  logic        armed_q, armed_d;
  logic [31:0] pre_q, pre_d;
  logic [15:0] t1_q, t1_d;
  logic [15:0] t2_q, t2_d;
  logic [31:0] cst_q, cst_d;
  logic [71:0] pay_q, pay_d;
  logic [2:0]  err_q, err_d;
  logic [71:0] cand_q, cand_d;
  logic [3:0]  match_q, match_d;
  logic        valid_q, valid_d;
  logic [71:0] out_q, out_d;
  logic [7:0]  good_q, good_d;
  logic [7:0]  bad_q, bad_d;
  logic [2:0]  lerr_q, lerr_d;
  logic        ovr_q, ovr_d;
  logic [23:0] tmo_q, tmo_d;

  logic        frame_evt;
  logic        publish;

  assign frame_evt = frame_full & ~full_q & armed_q;

  always_comb begin
    st_d    = st_q;
    full_d  = frame_full;
    armed_d = 1'b1;
    pre_d   = pre_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    cst_d   = cst_q;
    pay_d   = pay_q;
    err_d   = err_q;
    cand_d  = cand_q;
    match_d = match_q;
    good_d  = good_q;
    bad_d   = bad_q;
    lerr_d  = lerr_q;
    publish = 1'b0;

    unique case (st_q)
      StWait: begin
        if (frame_evt) begin
          pre_d = preamble;
          t1_d  = type_1;
          t2_d  = type_2;
          cst_d = constant;
          pay_d = {thermostat_id, room_temp, set_temp, state};
          st_d  = StCheck;
        end
      end
      StCheck: begin
        // Payload layout: id[71:40], room[39:24], set[23:8], state[7:0].
        if (pre_q != PREAMBLE) begin
          err_d = 3'd1;
        end else if (cst_q != CONSTANT) begin
          err_d = 3'd2;
        end else if (t1_q != t2_q) begin
          err_d = 3'd3;
        end else if (pay_q[39:24] < TEMP_MIN || pay_q[39:24] > TEMP_MAX ||
                     pay_q[23:8] < TEMP_MIN || pay_q[23:8] > TEMP_MAX) begin
          err_d = 3'd4;
        end else begin
          err_d = 3'd0;
        end
        st_d = StCommit;
      end
      StCommit: begin
        st_d = StWait;
        if (err_q != 3'd0) begin
          bad_d   = (bad_q == 8'hFF) ? bad_q : bad_q + 8'd1;
          lerr_d  = err_q;
          match_d = 4'd0;
        end else begin
          good_d = (good_q == 8'hFF) ? good_q : good_q + 8'd1;
          if (pay_q == cand_q && match_q != 4'd0) begin
            match_d = (match_q >= RepeatCnt) ? RepeatCnt : match_q + 4'd1;
          end else begin
            cand_d  = pay_q;
            match_d = 4'd1;
          end
          // Publish only on the transition into RepeatCnt, not while saturated there.
          publish = (match_d == RepeatCnt) && (match_q != RepeatCnt || cand_d != cand_q);
        end
      end
      default: st_d = StWait;
    endcase

    valid_d = valid_q;
    out_d   = out_q;
    ovr_d   = ovr_q;
    if (publish) begin
      out_d   = pay_q;
      valid_d = 1'b1;
      if (valid_q && !out_ready) begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (publish) begin
      tmo_d = 24'd0;
    end else if (tmo_q != TIMEOUT) begin
      tmo_d = tmo_q + 24'd1;
    end else begin
      tmo_d = tmo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StWait;
      full_q  <= 1'b0;
      armed_q <= 1'b0;
      pre_q   <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      cst_q   <= '0;
      pay_q   <= '0;
      err_q   <= '0;
      cand_q  <= '0;
      match_q <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      lerr_q  <= '0;
      ovr_q   <= 1'b0;
      tmo_q   <= TIMEOUT;
    end else begin
      st_q    <= st_d;
      full_q  <= full_d;
      armed_q <= armed_d;
      pre_q   <= pre_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      cst_q   <= cst_d;
      pay_q   <= pay_d;
      err_q   <= err_d;
      cand_q  <= cand_d;
      match_q <= match_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      lerr_q  <= lerr_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign out_valid         = valid_q;
  assign out_thermostat_id = out_q[71:40];
  assign out_room_temp     = out_q[39:24];
  assign out_set_temp      = out_q[23:8];
  assign out_state         = out_q[7:0];
  assign good_count        = good_q;
  assign bad_count         = bad_q;
  assign last_error        = lerr_q;
  assign overrun           = ovr_q;
  assign stale             = (tmo_q == TIMEOUT);

endmodule

// File: tb/tb_frame_validator.sv
module tb_frame_validator;

  typedef struct {
    logic [31:0] pre;
    logic [15:0] t1;
    logic [15:0] t2;
    logic [31:0] cst;
    logic [31:0] id;
    logic [15:0] room;
    logic [15:0] set;
    logic [7:0]  st;
  } frame_t;

  typedef struct {
    frame_t     f;
    logic       pub;
    logic [7:0] good;
    logic [7:0] bad;
    logic [2:0] err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_full = 1'b0;
  logic [31:0] preamble = '0;
  logic [15:0] type_1 = '0;
  logic [15:0] type_2 = '0;
  logic [31:0] constant = '0;
  logic [31:0] thermostat_id = '0;
  logic [15:0] room_temp = '0;
  logic [15:0] set_temp = '0;
  logic [7:0]  state = '0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [31:0] out_thermostat_id;
  logic [15:0] out_room_temp;
  logic [15:0] out_set_temp;
  logic [7:0]  out_state;
  logic [7:0]  good_count;
  logic [7:0]  bad_count;
  logic [2:0]  last_error;
  logic        overrun;
  logic        stale;

  frame_validator #(.TIMEOUT(24'd100)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .frame_full        (frame_full),
    .preamble          (preamble),
    .type_1            (type_1),
    .type_2            (type_2),
    .constant          (constant),
    .thermostat_id     (thermostat_id),
    .room_temp         (room_temp),
    .set_temp          (set_temp),
    .state             (state),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_thermostat_id (out_thermostat_id),
    .out_room_temp     (out_room_temp),
    .out_set_temp      (out_set_temp),
    .out_state         (out_state),
    .good_count        (good_count),
    .bad_count         (bad_count),
    .last_error        (last_error),
    .overrun           (overrun),
    .stale             (stale)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic frame_t fr(input logic [31:0] id, input logic [15:0] room,
                                input logic [15:0] set, input logic [7:0] st);
    frame_t f;
    f.pre = 32'hAAAA_AAAA;
    f.t1 = 16'h0055;
    f.t2 = 16'h0055;
    f.cst = 32'h0;
    f.id = id;
    f.room = room;
    f.set = set;
    f.st = st;
    return f;
  endfunction

  function automatic vec_t mk(input frame_t f, input logic pub, input logic [7:0] good,
                              input logic [7:0] bad, input logic [2:0] err);
    vec_t v;
    v.f = f;
    v.pub = pub;
    v.good = good;
    v.bad = bad;
    v.err = err;
    return v;
  endfunction

  function automatic logic [71:0] pl(input frame_t f);
    return {f.id, f.room, f.set, f.st};
  endfunction

  function automatic logic [71:0] out_pl();
    return {out_thermostat_id, out_room_temp, out_set_temp, out_state};
  endfunction

  task automatic apply(input frame_t f);
    preamble = f.pre;
    type_1 = f.t1;
    type_2 = f.t2;
    constant = f.cst;
    thermostat_id = f.id;
    room_temp = f.room;
    set_temp = f.set;
    state = f.st;
  endtask

  // Raises frame_full after an edge and returns #1 after the commit edge (third edge later).
  task automatic send(input frame_t f, output logic pre_valid);
    @(posedge clk);
    #1;
    apply(f);
    frame_full = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    pre_valid = out_valid;
    @(posedge clk);
    #1;
    frame_full = 1'b0;
  endtask

  vec_t   vecs[$];
  frame_t f, p1, x, y, z, w;
  logic   pv;

  initial begin
    p1 = fr(32'h1234_5678, 16'd720, 16'd680, 8'h03);
    vecs.push_back(mk(p1, 1'b0, 8'd1, 8'd0, 3'd0));
    vecs.push_back(mk(p1, 1'b1, 8'd2, 8'd0, 3'd0));
    f = p1; f.pre = 32'hAAAA_AAAB;
    vecs.push_back(mk(f, 1'b0, 8'd2, 8'd1, 3'd1));
    f = p1; f.t1 = 16'd1; f.t2 = 16'd2;
    vecs.push_back(mk(f, 1'b0, 8'd2, 8'd2, 3'd3));
    f = p1; f.room = 16'd1000;
    vecs.push_back(mk(f, 1'b0, 8'd2, 8'd3, 3'd4));
    // Same payload as the old candidate, but the bad frames reset the match count.
    vecs.push_back(mk(p1, 1'b0, 8'd3, 8'd3, 3'd4));
    vecs.push_back(mk(fr(32'hAAAA_0001, 16'd320, 16'd990, 8'h00), 1'b0, 8'd4, 8'd3, 3'd4));
    f = fr(32'hBBBB_0002, 16'd500, 16'd501, 8'h7F);
    vecs.push_back(mk(f, 1'b0, 8'd5, 8'd3, 3'd4));
    vecs.push_back(mk(f, 1'b1, 8'd6, 8'd3, 3'd4));
    vecs.push_back(mk(f, 1'b0, 8'd7, 8'd3, 3'd4));
    f.cst = 32'd1;
    vecs.push_back(mk(f, 1'b0, 8'd7, 8'd4, 3'd2));
    f = fr(32'hBBBB_0002, 16'd500, 16'd319, 8'h7F);
    vecs.push_back(mk(f, 1'b0, 8'd7, 8'd5, 3'd4));
    f = fr(32'hBBBB_0002, 16'd991, 16'd500, 8'h7F);
    vecs.push_back(mk(f, 1'b0, 8'd7, 8'd6, 3'd4));
    f = p1; f.pre = 32'h0; f.cst = 32'h1;
    vecs.push_back(mk(f, 1'b0, 8'd7, 8'd7, 3'd1));
    f = fr(32'hCCCC_0003, 16'd990, 16'd320, 8'h11);
    vecs.push_back(mk(f, 1'b0, 8'd8, 8'd7, 3'd1));
    vecs.push_back(mk(f, 1'b1, 8'd9, 8'd7, 3'd1));

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 72'(out_valid), 72'd0);
    check("rst_stale", 72'(stale), 72'd1);
    check("rst_good", 72'(good_count), 72'd0);
    check("rst_bad", 72'(bad_count), 72'd0);
    check("rst_lerr", 72'(last_error), 72'd0);
    check("rst_ovr", 72'(overrun), 72'd0);
    check("rst_payload", out_pl(), 72'd0);
    rst_n = 1'b1;

    out_ready = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].f, pv);
      check($sformatf("v%0d_prevalid", i), 72'(pv), 72'd0);
      check($sformatf("v%0d_valid", i), 72'(out_valid), 72'(vecs[i].pub));
      check($sformatf("v%0d_good", i), 72'(good_count), 72'(vecs[i].good));
      check($sformatf("v%0d_bad", i), 72'(bad_count), 72'(vecs[i].bad));
      check($sformatf("v%0d_lerr", i), 72'(last_error), 72'(vecs[i].err));
      if (vecs[i].pub) begin
        check($sformatf("v%0d_payload", i), out_pl(), pl(vecs[i].f));
        check($sformatf("v%0d_stale", i), 72'(stale), 72'd0);
        @(posedge clk);
        #1;
        check($sformatf("v%0d_accept", i), 72'(out_valid), 72'd0);
      end
    end

    // Overrun: publish X then Y while the consumer stalls
    x = fr(32'hDEAD_0001, 16'd400, 16'd450, 8'h01);
    y = fr(32'hDEAD_0002, 16'd401, 16'd451, 8'h02);
    out_ready = 1'b0;
    send(x, pv);
    send(x, pv);
    check("ovr_x_valid", 72'(out_valid), 72'd1);
    check("ovr_x_payload", out_pl(), pl(x));
    check("ovr_x_flag", 72'(overrun), 72'd0);
    send(y, pv);
    check("ovr_hold_payload", out_pl(), pl(x));
    send(y, pv);
    check("ovr_y_valid", 72'(out_valid), 72'd1);
    check("ovr_y_payload", out_pl(), pl(y));
    check("ovr_y_flag", 72'(overrun), 72'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("ovr_accept_valid", 72'(out_valid), 72'd0);
    check("ovr_accept_payload", out_pl(), pl(y));
    check("ovr_sticky", 72'(overrun), 72'd1);

    // Timeout: stale stays low for 99 edges after the publish edge, rises on the 100th
    out_ready = 1'b1;
    z = fr(32'h5A5A_0003, 16'd700, 16'd650, 8'h04);
    send(z, pv);
    send(z, pv);
    check("tmo_pub", 72'(out_valid), 72'd1);
    check("tmo_stale0", 72'(stale), 72'd0);
    repeat (99) @(posedge clk);
    #1;
    check("tmo_stale99", 72'(stale), 72'd0);
    @(posedge clk);
    #1;
    check("tmo_stale100", 72'(stale), 72'd1);

    // Reset asserted while the second identical frame sits in CHECK
    w = fr(32'h0BAD_F00D, 16'd600, 16'd600, 8'h05);
    send(w, pv);
    @(posedge clk);
    #1;
    apply(w);
    frame_full = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 72'(out_valid), 72'd0);
    check("mid_rst_good", 72'(good_count), 72'd0);
    check("mid_rst_bad", 72'(bad_count), 72'd0);
    check("mid_rst_ovr", 72'(overrun), 72'd0);
    check("mid_rst_stale", 72'(stale), 72'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_valid", 72'(out_valid), 72'd0);
    check("post_rst_good", 72'(good_count), 72'd0);
    frame_full = 1'b0;
    send(w, pv);
    check("recover_nopub", 72'(out_valid), 72'd0);
    send(w, pv);
    check("recover_pub", 72'(out_valid), 72'd1);
    check("recover_payload", out_pl(), pl(w));
    check("recover_good", 72'(good_count), 72'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
